ahb_lite_burst_master: RTL

- AHB-Lite initiator that drives the SDRAM controller's AHB slave port. It converts a simple command/response interface into word-wide AHB transfers of SINGLE, INCR or INCR4 type.
- It sits between the SID capture/playback logic and the SDRAM controller on the HCLK domain.
- It overlaps the address and data phases, honours slave wait states, and cancels the remaining beats of a burst on an ERROR response.

---
 rtl/ahb_pkg.sv | 44 ++++
 rtl/ahb_lite_burst_master.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the burst master's state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    // Zero beats means one; anything past the maximum saturates.
    function automatic logic [2:0] clamp_len(input logic [2:0] len, input logic [2:0] max_len);
        if (len == 3'd0) begin
            return 3'd1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

    function automatic logic [2:0] burst_for_len(input logic [2:0] len);
        case (len)
            3'd1:    return HBURST_SINGLE;
            3'd4:    return HBURST_INCR4;
            default: return HBURST_INCR;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_burst_master.sv
// AHB-Lite initiator: turns one command into a SINGLE/INCR/INCR4 word burst with
// pipelined address/data phases, wait-state handling and ERROR cancellation.
module ahb_lite_burst_master
    import ahb_pkg::*;
#(
    parameter int unsigned MAX_BEATS = 4,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [2:0]        cmd_len,
    input  logic [127:0]      cmd_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              done,
    output logic              done_err,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [2:0]        HBURST,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic [1:0]        HRESP
);

    localparam logic [2:0] LP_MAX_BEATS = 3'(MAX_BEATS);

    state_t            r_state, w_state;
    logic [2:0]        r_len, w_len;
    logic [2:0]        r_abeat, w_abeat;
    logic [2:0]        r_dbeat, w_dbeat;
    logic [127:0]      r_wdata, w_wdata;

    logic [1:0]        w_htrans;
    logic [ADDR_W-1:0] w_haddr;
    logic              w_hwrite;
    logic [2:0]        w_hburst;
    logic [31:0]       w_hwdata;
    logic              w_cmd_ready;
    logic              w_rsp_valid;
    logic [31:0]       w_rsp_rdata;
    logic              w_done;
    logic              w_done_err;

    logic [2:0]        w_cmd_len;
    logic [ADDR_W-1:0] w_cmd_addr;
    logic              w_err;
    logic [1:0]        w_nidx;
    logic [31:0]       w_nword;

    assign HSIZE      = HSIZE_WORD;
    assign w_cmd_len  = clamp_len(cmd_len, LP_MAX_BEATS);
    assign w_cmd_addr = cmd_addr & ~ADDR_W'(3);
    assign w_err      = (HRESP == HRESP_ERROR) || HRESP[1];
    assign w_nidx     = r_dbeat[1:0] + 2'd1;
    assign w_nword    = r_wdata[{w_nidx, 5'd0} +: 32];

    always_comb begin
        w_state     = r_state;
        w_len       = r_len;
        w_abeat     = r_abeat;
        w_dbeat     = r_dbeat;
        w_wdata     = r_wdata;
        w_htrans    = HTRANS;
        w_haddr     = HADDR;
        w_hwrite    = HWRITE;
        w_hburst    = HBURST;
        w_hwdata    = HWDATA;
        w_cmd_ready = cmd_ready;
        w_rsp_valid = 1'b0;
        w_rsp_rdata = rsp_rdata;
        w_done      = 1'b0;
        w_done_err  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid && cmd_ready) begin
                    w_state     = ST_ADDR;
                    w_cmd_ready = 1'b0;
                    w_htrans    = HTRANS_NONSEQ;
                    w_haddr     = w_cmd_addr;
                    w_hwrite    = cmd_write;
                    w_hburst    = burst_for_len(w_cmd_len);
                    w_len       = w_cmd_len;
                    w_abeat     = 3'd0;
                    w_dbeat     = 3'd0;
                    w_wdata     = cmd_wdata;
                end
            end

            ST_ADDR: begin
                if (HREADY) begin
                    w_state  = ST_DATA;
                    w_dbeat  = 3'd0;
                    w_hwdata = r_wdata[31:0];
                    if (r_len > 3'd1) begin
                        w_htrans = HTRANS_SEQ;
                        w_haddr  = HADDR + ADDR_W'(4);
                        w_abeat  = 3'd1;
                    end else begin
                        w_htrans = HTRANS_IDLE;
                    end
                end
            end

            ST_DATA: begin
                // The next address was still on the bus; cancelling it here is the
                // one place control changes while HREADY is low.
                if (w_err) begin
                    w_htrans = HTRANS_IDLE;
                    if (HREADY) begin
                        w_state    = ST_IDLE;
                        w_done     = 1'b1;
                        w_done_err = 1'b1;
                    end else begin
                        w_state = ST_ERR;
                    end
                end else if (HREADY) begin
                    if (!HWRITE) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_rdata = HRDATA;
                    end
                    if (r_dbeat == r_len - 3'd1) begin
                        w_state  = ST_IDLE;
                        w_htrans = HTRANS_IDLE;
                        w_done   = 1'b1;
                    end else begin
                        w_dbeat  = r_dbeat + 3'd1;
                        w_hwdata = w_nword;
                        if (r_abeat + 3'd1 < r_len) begin
                            w_htrans = HTRANS_SEQ;
                            w_haddr  = HADDR + ADDR_W'(4);
                            w_abeat  = r_abeat + 3'd1;
                        end else begin
                            w_htrans = HTRANS_IDLE;
                        end
                    end
                end
            end

            ST_ERR: begin
                if (HREADY) begin
                    w_state    = ST_IDLE;
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end
            end

            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state   <= ST_IDLE;
            r_len     <= 3'd1;
            r_abeat   <= '0;
            r_dbeat   <= '0;
            r_wdata   <= '0;
            HTRANS    <= HTRANS_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HBURST    <= HBURST_SINGLE;
            HWDATA    <= '0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            done      <= 1'b0;
            done_err  <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_len     <= w_len;
            r_abeat   <= w_abeat;
            r_dbeat   <= w_dbeat;
            r_wdata   <= w_wdata;
            HTRANS    <= w_htrans;
            HADDR     <= w_haddr;
            HWRITE    <= w_hwrite;
            HBURST    <= w_hburst;
            HWDATA    <= w_hwdata;
            cmd_ready <= w_cmd_ready;
            rsp_valid <= w_rsp_valid;
            rsp_rdata <= w_rsp_rdata;
            done      <= w_done;
            done_err  <= w_done_err;
        end
    end

endmodule
